// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: 2-entry skid buffer with registered branch redirect and forwarding tap.
// Optional performance counters are enabled by defining EX_MEM_PERF_CNT_EN.
module ex_mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_r,
  input  logic [4:0]  in_rd,
  input  logic        in_wb,
  input  logic [1:0]  in_br,
  input  logic [31:0] in_br_tgt,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_r,
  output logic [4:0]  out_rd,
  output logic        out_wb,
  output logic        br_taken,
  output logic [31:0] br_tgt,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_r,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_br
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e      state_q, state_d;
  logic        in_ready_q;
  logic [31:0] head_r_q, head_r_d, skid_r_q, skid_r_d;
  logic [4:0]  head_rd_q, head_rd_d, skid_rd_q, skid_rd_d;
  logic        head_wb_q, head_wb_d, skid_wb_q, skid_wb_d;
  logic        br_taken_q, br_taken_d;
  logic [31:0] br_tgt_q, br_tgt_d;
  logic        accept, pop, zero, br_hit;

  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;
  assign zero      = (in_r == 32'h0);
  // Reserved encoding 2'b11 falls through as "no branch".
  assign br_hit    = ((in_br == 2'b01) & zero) | ((in_br == 2'b10) & ~zero);

  always_comb begin
    state_d   = state_q;
    head_r_d  = head_r_q;
    head_rd_d = head_rd_q;
    head_wb_d = head_wb_q;
    skid_r_d  = skid_r_q;
    skid_rd_d = skid_rd_q;
    skid_wb_d = skid_wb_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            head_r_d  = in_r;
            head_rd_d = in_rd;
            head_wb_d = in_wb;
            state_d   = StOne;
          end
        end
        StOne: begin
          if (accept && pop) begin
            head_r_d  = in_r;
            head_rd_d = in_rd;
            head_wb_d = in_wb;
          end else if (accept) begin
            skid_r_d  = in_r;
            skid_rd_d = in_rd;
            skid_wb_d = in_wb;
            state_d   = StTwo;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (pop) begin
            head_r_d  = skid_r_q;
            head_rd_d = skid_rd_q;
            head_wb_d = skid_wb_q;
            state_d   = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    br_taken_d = accept & br_hit & ~flush;
    br_tgt_d   = br_taken_d ? in_br_tgt : br_tgt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
      head_r_q   <= 32'h0;
      head_rd_q  <= 5'h0;
      head_wb_q  <= 1'b0;
      skid_r_q   <= 32'h0;
      skid_rd_q  <= 5'h0;
      skid_wb_q  <= 1'b0;
      br_taken_q <= 1'b0;
      br_tgt_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != StTwo);
      head_r_q   <= head_r_d;
      head_rd_q  <= head_rd_d;
      head_wb_q  <= head_wb_d;
      skid_r_q   <= skid_r_d;
      skid_rd_q  <= skid_rd_d;
      skid_wb_q  <= skid_wb_d;
      br_taken_q <= br_taken_d;
      br_tgt_q   <= br_tgt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_r     = head_r_q;
  assign out_rd    = head_rd_q;
  assign out_wb    = head_wb_q;
  assign br_taken  = br_taken_q;
  assign br_tgt    = br_tgt_q;
  assign fwd_valid = out_valid & head_wb_q & (head_rd_q != 5'h0);
  assign fwd_rd    = head_rd_q;
  assign fwd_r     = head_r_q;

`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_br_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_q <= 32'h0;
      perf_br_q    <= 32'h0;
    end else begin
      if (out_valid && !out_ready) perf_stall_q <= perf_stall_q + 32'h1;
      if (br_taken_q)              perf_br_q    <= perf_br_q + 32'h1;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_br    = perf_br_q;
`else
  assign perf_stall = 32'h0;
  assign perf_br    = 32'h0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed scenarios followed by randomized traffic,
// flushes and mid-run resets, checked against a queue-based behavioural model.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, in_wb, flush, out_valid, out_ready, out_wb;
  logic [31:0] in_r, in_br_tgt, out_r, br_tgt, fwd_r, perf_stall, perf_br;
  logic [4:0]  in_rd, out_rd, fwd_rd;
  logic [1:0]  in_br;
  logic        br_taken, fwd_valid;

  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r),
    .in_rd(in_rd), .in_wb(in_wb), .in_br(in_br), .in_br_tgt(in_br_tgt), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_rd(out_rd),
    .out_wb(out_wb), .br_taken(br_taken), .br_tgt(br_tgt), .fwd_valid(fwd_valid),
    .fwd_rd(fwd_rd), .fwd_r(fwd_r), .perf_stall(perf_stall), .perf_br(perf_br)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] r;
    logic [4:0]  rd;
    logic        wb;
  } ent_t;

  int          checks = 0;
  int          errors = 0;
  ent_t        sb[$];
  int          occ = 0;
  logic        exp_bt = 1'b0;
  logic [31:0] exp_tgt = 32'h0;
  logic [31:0] exp_stall = 32'h0;
  logic [31:0] exp_brc = 32'h0;
  logic        was_rst = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy and FIFO contents advance at each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        occ = 0;
        sb.delete();
        exp_bt = 1'b0;
        exp_tgt = 32'h0;
        exp_stall = 32'h0;
        exp_brc = 32'h0;
        was_rst = 1'b1;
      end else begin
        automatic bit acc = in_valid && (occ < 2);
        automatic bit pp  = (occ > 0) && out_ready;
        was_rst = 1'b0;
        if (occ > 0 && !out_ready) exp_stall = exp_stall + 32'h1;
        if (exp_bt) exp_brc = exp_brc + 32'h1;
        if (flush) begin
          occ = 0;
          sb.delete();
          exp_bt = 1'b0;
        end else begin
          exp_bt = acc && ((in_br == 2'b01 && in_r == 32'h0) ||
                           (in_br == 2'b10 && in_r != 32'h0));
          if (exp_bt) exp_tgt = in_br_tgt;
          occ = occ - (pp ? 1 : 0) + (acc ? 1 : 0);
          if (acc) sb.push_back('{r: in_r, rd: in_rd, wb: in_wb});
        end
      end
    end
  end

  // Monitor: compares DUT outputs mid-cycle and retires the head on a handshake.
  initial begin
    forever begin
      @(negedge clk);
      chk("out_valid", 32'(out_valid), 32'(occ > 0));
      chk("in_ready", 32'(in_ready), 32'(occ < 2));
      chk("br_taken", 32'(br_taken), 32'(exp_bt));
      chk("br_tgt", br_tgt, exp_tgt);
`ifdef EX_MEM_PERF_CNT_EN
      chk("perf_stall", perf_stall, exp_stall);
      chk("perf_br", perf_br, exp_brc);
`else
      chk("perf_stall", perf_stall, 32'h0);
      chk("perf_br", perf_br, 32'h0);
`endif
      if (was_rst) begin
        chk("rst_out_r", out_r, 32'h0);
        chk("rst_out_rd", 32'(out_rd), 32'h0);
        chk("rst_out_wb", 32'(out_wb), 32'h0);
        chk("rst_fwd_valid", 32'(fwd_valid), 32'h0);
      end
      if (occ > 0 && sb.size() > 0) begin
        automatic ent_t e = sb[0];
        chk("out_r", out_r, e.r);
        chk("out_rd", 32'(out_rd), 32'(e.rd));
        chk("out_wb", 32'(out_wb), 32'(e.wb));
        chk("fwd_valid", 32'(fwd_valid), 32'(e.wb && e.rd != 5'd0));
        chk("fwd_rd", 32'(fwd_rd), 32'(e.rd));
        chk("fwd_r", fwd_r, e.r);
        if (out_ready && !flush && rst_n) void'(sb.pop_front());
      end else begin
        chk("fwd_valid_idle", 32'(fwd_valid), 32'h0);
      end
    end
  end

  task automatic drive(input logic iv, input logic [31:0] r, input logic [4:0] rd,
                       input logic wb, input logic [1:0] br, input logic [31:0] tgt,
                       input logic fl, input logic ordy);
    in_valid  = iv;
    in_r      = r;
    in_rd     = rd;
    in_wb     = wb;
    in_br     = br;
    in_br_tgt = tgt;
    flush     = fl;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 5'd0, 1'b0, 2'b00, 32'h0, 1'b0, ordy);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Single entry straight through, with forwarding.
    drive(1'b1, 32'h5, 5'd3, 1'b1, 2'b00, 32'h0, 1'b0, 1'b1);
    idle(1'b1, 2);

    // Fill both slots while stalled, then drain; the stall window also exercises perf_stall.
    drive(1'b1, 32'hA, 5'd4, 1'b1, 2'b00, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'hB, 5'd5, 1'b1, 2'b00, 32'h0, 1'b0, 1'b0);
    idle(1'b0, 6);
    idle(1'b1, 3);

    // BEQ taken, then BEQ not taken, then BNE taken; reserved type never redirects.
    drive(1'b1, 32'h0, 5'd0, 1'b0, 2'b01, 32'h0040_0100, 1'b0, 1'b1);
    idle(1'b1, 2);
    drive(1'b1, 32'h1, 5'd0, 1'b0, 2'b01, 32'h0040_0200, 1'b0, 1'b1);
    idle(1'b1, 2);
    drive(1'b1, 32'h7, 5'd1, 1'b1, 2'b10, 32'h0000_0300, 1'b0, 1'b1);
    drive(1'b1, 32'h0, 5'd1, 1'b1, 2'b11, 32'h0000_0400, 1'b0, 1'b1);
    idle(1'b1, 2);

    // Flush from the full state, with a taken branch offered in the same cycle.
    drive(1'b1, 32'h11, 5'd6, 1'b1, 2'b00, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h22, 5'd7, 1'b1, 2'b00, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h0, 5'd8, 1'b1, 2'b01, 32'h0000_0500, 1'b1, 1'b0);
    idle(1'b1, 3);
    drive(1'b1, 32'h0, 5'd8, 1'b1, 2'b01, 32'h0000_0600, 1'b1, 1'b1);
    idle(1'b1, 2);

    // Write-back to x0 must not forward.
    drive(1'b1, 32'h99, 5'd0, 1'b1, 2'b00, 32'h0, 1'b0, 1'b1);
    idle(1'b1, 2);

    // Reset while holding two entries.
    drive(1'b1, 32'h33, 5'd9, 1'b1, 2'b00, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h44, 5'd10, 1'b1, 2'b00, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    drive(1'b1, 32'h0, 5'd11, 1'b1, 2'b01, 32'h0000_0700, 1'b1, 1'b1);
    rst_n = 1'b1;
    idle(1'b1, 2);

    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      drive(($urandom_range(0, 3) != 0),
            (($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom)),
            5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)),
            32'($urandom),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 2) != 0));
    end
    rst_n = 1'b1;
    idle(1'b1, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; ports are named clk and rst_n, all other ports as listed below.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  synchronous active-low reset.
REQ-004 in_valid  in  1  ALU result present this cycle.
REQ-005 in_ready  out  1  stage can accept an entry.
REQ-006 in_r  in  32  ALU result word.
REQ-007 in_rd  in  5  destination register index.
REQ-008 in_wb  in  1  register write-back enable.
REQ-009 in_br  in  2  branch type: 00 none, 01 BEQ (taken if in_r==0), 10 BNE (taken if in_r!=0), 11 reserved, treated as none.
REQ-010 in_br_tgt  in  32  branch target address.
REQ-011 flush  in  1  discard all held entries.
REQ-012 out_valid / out_ready  out / in  1 each  downstream handshake.
REQ-013 out_r  out  32; out_rd  out  5; out_wb  out  1  head-entry payload.
REQ-014 br_taken  out  1; br_tgt  out  32  registered branch redirect.
REQ-015 fwd_valid  out  1; fwd_rd  out  5; fwd_r  out  32  forwarding tap = head entry, fwd_valid = out_valid & out_wb & (out_rd!=0).
REQ-016 perf_stall  out  32; perf_br  out  32  performance counters (see Configuration).

Function
REQ-017 Storage SHALL be a 2-entry skid buffer (head, skid); states EMPTY, ONE, TWO.
REQ-018 Accept = in_valid & in_ready; pop = out_valid & out_ready.
REQ-019 in_ready SHALL be a registered signal, 1 in EMPTY and ONE, 0 in TWO.
REQ-020 Transitions: EMPTY+accept->ONE; ONE+accept&!pop->TWO; ONE+pop&!accept->EMPTY; ONE+accept&pop->ONE (new entry becomes head); TWO+pop->ONE (skid moves to head); otherwise hold.
REQ-021 Latency: an entry accepted in cycle N SHALL appear at out_* in cycle N+1 when the stage was EMPTY or popped in cycle N.
REQ-022 Payload SHALL be held stable while out_valid=1 and out_ready=0; ordering strictly FIFO.
REQ-023 Zero flag SHALL be computed internally as (in_r==32'h0); no ALU zero input is used.
REQ-024 br_taken SHALL pulse 1 for exactly one cycle, cycle N+1, when a branch entry is accepted in cycle N and its condition holds; br_tgt SHALL load in_br_tgt in the same cycle and hold otherwise.
REQ-025 Branch entries SHALL still traverse the buffer with out_wb as supplied.
REQ-026 flush SHALL, in the cycle it is sampled, discard both entries and any same-cycle input, force state EMPTY, br_taken=0, in_ready=1 next cycle; flush overrides accept and pop.
REQ-027 Same-cycle accept of a taken branch and flush: flush wins, no br_taken pulse.

Reset
REQ-028 On rst_n=0 at a rising edge: state EMPTY, in_ready=1, out_valid=0, out_r=0, out_rd=0, out_wb=0, br_taken=0, br_tgt=0, fwd_valid=0, perf counters=0.
REQ-029 Reset mid-transfer SHALL drop held entries without emitting them; reset overrides flush and all inputs.

Configuration
REQ-030 Macro EX_MEM_PERF_CNT_EN: when defined, perf_stall SHALL increment each cycle out_valid&!out_ready and perf_br SHALL increment on each br_taken pulse, both 32-bit wrapping 32'hFFFFFFFF->0, cleared only by reset.
REQ-031 Without EX_MEM_PERF_CNT_EN, perf_stall and perf_br SHALL be tied to 32'h0 and no counter registers synthesised; all other behaviour identical.

Verification
REQ-032 Reset, then in_valid=1, in_r=32'h5, in_rd=3, in_wb=1, out_ready=1 -> next cycle out_valid=1, out_r=5, fwd_valid=1, fwd_rd=3.
REQ-033 out_ready=0, push 32'hA then 32'hB -> in_ready=0 after second accept; raise out_ready -> out_r=A then B on consecutive cycles, in_ready returns 1.
REQ-034 in_br=01, in_r=0, in_br_tgt=32'h0040_0100 -> br_taken=1 one cycle, br_tgt=32'h0040_0100; repeat with in_r=1 -> br_taken stays 0.
REQ-035 State TWO, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, no entry later emitted.
REQ-036 With EX_MEM_PERF_CNT_EN, out_valid=1, out_ready=0 for 7 cycles -> perf_stall=7; without macro perf_stall=0.
REQ-037 in_rd=0, in_wb=1 accepted -> out_valid=1, fwd_valid=0.
